// File: rtl/usb_nrzi_stuff_enc.sv
// USB transmit line encoder: NRZI with optional bit stuffing after STUFF_LEN
// consecutive 1s. One bit time per clock; the source is stalled during a stuffed 0.
module usb_nrzi_stuff_enc #(
  parameter int       STUFF_LEN  = 6,
  parameter logic     IDLE_LEVEL = 1'b1,
  parameter int       CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             stuff_en,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic             out_stuff,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] ONES_LAST = OW'(STUFF_LEN - 1);

  logic             line_q, line_d;
  logic             valid_q, valid_d;
  logic             stuff_q, stuff_d;
  logic             pend_q, pend_d;
  logic [OW-1:0]    ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign in_ready = ~pend_q;
  assign accept   = in_valid & ~pend_q & ~clr;

  always_comb begin
    line_d  = line_q;
    valid_d = 1'b0;
    stuff_d = 1'b0;
    pend_d  = pend_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;
    if (clr) begin
      // Packet boundary: any pending stuff is dropped, statistics survive.
      line_d = IDLE_LEVEL;
      ones_d = '0;
      pend_d = 1'b0;
    end else if (pend_q) begin
      line_d  = ~line_q;
      valid_d = 1'b1;
      stuff_d = 1'b1;
      pend_d  = 1'b0;
      ones_d  = '0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b1;
      line_d  = in_data ? line_q : ~line_q;
      if (!in_data) begin
        ones_d = '0;
      end else if (ones_q == ONES_LAST) begin
        // With stuffing off the run length pins at its last value, so
        // re-enabling mid-run stuffs on the very next 1.
        if (stuff_en) begin
          ones_d = '0;
          pend_d = 1'b1;
        end
      end else begin
        ones_d = ones_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= IDLE_LEVEL;
      valid_q <= 1'b0;
      stuff_q <= 1'b0;
      pend_q  <= 1'b0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      line_q  <= line_d;
      valid_q <= valid_d;
      stuff_q <= stuff_d;
      pend_q  <= pend_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = line_q;
  assign out_valid = valid_q;
  assign out_stuff = stuff_q;
  assign stuff_cnt = cnt_q;

endmodule
